// File: rtl/rst_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rst_seq_pkg : shared types and widths for the reset sequencer        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rst_seq_pkg;

    localparam int SEQ_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rst_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rst_sync_2ff : two-flop async-assert / sync-deassert reset synchro   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rst_sync_2ff (
    input  logic clk_i,
    input  logic arst_n_i,
    output logic rst_n_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_n_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rst_seq_gen : staggered release of N active-low channel resets       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned STAGE_GAP   = 4,
    parameter bit          REVERSE     = 1'b0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 SYSCLK,
    input  logic                 NSYSRESET,
    input  logic                 sw_rst_req,
    output logic [N_CH-1:0]      rst_n_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic [SEQ_CNT_W-1:0] seq_cnt_o
);

    localparam int unsigned          STG_W      = $clog2(N_CH + 1);
    localparam logic [CNT_W-1:0]     HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0]     STAGE_LAST = STG_W'(N_CH - 1);
    localparam logic [SEQ_CNT_W-1:0] SEQ_MAX    = '1;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STG_W-1:0]       stage_q, stage_d;
    logic [N_CH-1:0]        rst_n_q, rst_n_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [SEQ_CNT_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic                   w_rst_sync_n;
    logic [N_CH-1:0]        w_rel_mask;

    rst_sync_2ff u_rst_sync (
        .clk_i    (SYSCLK),
        .arst_n_i (NSYSRESET),
        .rst_n_o  (w_rst_sync_n)
    );

    // One-hot bit of the channel released at a given stage, honouring order.
    function automatic logic [N_CH-1:0] chan_mask(input logic [STG_W-1:0] stg);
        logic [N_CH-1:0] m;
        m = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (REVERSE) begin
                if (STG_W'(N_CH - 1 - i) == stg) m[i] = 1'b1;
            end else begin
                if (STG_W'(i) == stg) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    assign w_rel_mask = chan_mask(stage_q);

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            stage_q   <= '0;
            rst_n_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            seq_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            rst_n_q   <= rst_n_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            seq_cnt_q <= seq_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        rst_n_d   = rst_n_q;
        done_d    = done_q;
        busy_d    = busy_q;
        seq_cnt_d = seq_cnt_q;

        if (sw_rst_req) begin
            // Software restart overrides every counting decision below.
            state_d = ST_HOLD;
            cnt_d   = '0;
            stage_d = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            if (seq_cnt_q != SEQ_MAX) begin
                seq_cnt_d = seq_cnt_q + SEQ_CNT_W'(1);
            end
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (w_rst_sync_n) begin
                        if (cnt_q == HOLD_LAST) begin
                            rst_n_d = rst_n_q | w_rel_mask;
                            cnt_d   = '0;
                            stage_d = stage_q + STG_W'(1);
                            if (stage_q == STAGE_LAST) begin
                                state_d = ST_RUN;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end else begin
                                state_d = ST_RELEASE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        rst_n_d = rst_n_q | w_rel_mask;
                        cnt_d   = '0;
                        stage_d = stage_q + STG_W'(1);
                        if (stage_q == STAGE_LAST) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    assign rst_n_o   = rst_n_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;
    assign seq_cnt_o = seq_cnt_q;

endmodule
`default_nettype wire
